// File: rtl/counter_pkg.sv
// ---------------------------------------------------------------------------
// counter_pkg : shared width default and direction encoding for the counter
// Revision    : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package counter_pkg;

  localparam int DEFAULT_WIDTH = 3;

  typedef enum logic {
    DIR_DOWN = 1'b0,
    DIR_UP   = 1'b1
  } dir_e;

endpackage : counter_pkg

`default_nettype wire

// File: rtl/counter_next.sv
// ---------------------------------------------------------------------------
// counter_next : next-state arithmetic and wrap detection for the counter
// Revision     : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module counter_next
  import counter_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic [WIDTH-1:0] count,
  input  dir_e             dir,
  output logic [WIDTH-1:0] next_count,
  output logic             will_wrap
);

  localparam logic [WIDTH-1:0] C_ONE      = WIDTH'(1);
  localparam logic [WIDTH-1:0] C_ALL_ONES = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] C_ZERO     = '0;

  always_comb begin
    next_count = count;
    will_wrap  = 1'b0;
    if (dir == DIR_UP) begin
      next_count = count + C_ONE;
      will_wrap  = (count == C_ALL_ONES);
    end else begin
      next_count = count - C_ONE;
      will_wrap  = (count == C_ZERO);
    end
  end

endmodule : counter_next

`default_nettype wire

// File: rtl/three_bit_counter.sv
// ---------------------------------------------------------------------------
// three_bit_counter : up/down wrapping counter with terminal count and wrap pulse
// Revision          : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module three_bit_counter
  import counter_pkg::*;
#(
  parameter int WIDTH       = DEFAULT_WIDTH,
  parameter int RESET_VALUE = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             up_down,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             wrap
);

  localparam logic [WIDTH-1:0] C_RESET_VALUE = WIDTH'(RESET_VALUE);

  logic [WIDTH-1:0] r_count;
  logic             r_wrap;
  logic [WIDTH-1:0] w_next_count;
  logic             w_will_wrap;
  dir_e             w_dir;

  // Any non-1 level (including X) counts down, so the register never sees X.
  assign w_dir = (up_down === 1'b1) ? DIR_UP : DIR_DOWN;

  counter_next #(
    .WIDTH (WIDTH)
  ) u_counter_next (
    .count      (r_count),
    .dir        (w_dir),
    .next_count (w_next_count),
    .will_wrap  (w_will_wrap)
  );

  // rst is active-low and asynchronous.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_count <= C_RESET_VALUE;
      r_wrap  <= 1'b0;
    end else begin
      r_count <= w_next_count;
      r_wrap  <= w_will_wrap;
    end
  end

  assign count = r_count;
  assign wrap  = r_wrap;
  assign tc    = w_will_wrap;

endmodule : three_bit_counter

`default_nettype wire

// File: tb/tb_three_bit_counter.sv
// ---------------------------------------------------------------------------
// tb_three_bit_counter : directed stimulus with a queued scoreboard for three_bit_counter
// Revision             : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_three_bit_counter;

  typedef struct packed {
    logic [2:0] c;
    logic       t;
    logic       w;
  } exp_t;

  logic       clk;
  logic       rst;
  logic       up_down;
  logic [2:0] count;
  logic       tc;
  logic       wrap;
  logic       probe;

  exp_t  exp_q[$];
  string name_q[$];
  int    checks;
  int    failures;

  three_bit_counter #(
    .WIDTH       (3),
    .RESET_VALUE (0)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .up_down (up_down),
    .count   (count),
    .tc      (tc),
    .wrap    (wrap)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Monitor: compares on each falling edge, or on a mid-cycle probe strobe.
  always @(negedge clk or posedge probe) begin
    if (exp_q.size() > 0) begin
      exp_t  e;
      string n;
      e = exp_q.pop_front();
      n = name_q.pop_front();
      checks = checks + 1;
      if (count !== e.c || tc !== e.t || wrap !== e.w) begin
        failures = failures + 1;
        $display("FAIL %s: got count=%0d tc=%b wrap=%b, expected count=%0d tc=%b wrap=%b",
                 n, count, tc, wrap, e.c, e.t, e.w);
      end
    end
  end

  // Drive rst/up_down just after a rising edge and queue the state expected
  // before the next rising edge (count from the edge just taken, tc for the new direction).
  task automatic cyc(input logic r, input logic ud, input logic [2:0] ec,
                     input logic et, input logic ew, input string n);
    @(posedge clk);
    #2;
    rst     = r;
    up_down = ud;
    exp_q.push_back('{c: ec, t: et, w: ew});
    name_q.push_back(n);
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    probe    = 1'b0;
    rst      = 1'b0;
    up_down  = 1'b1;

    // Reset held while clk runs, even when counting down
    cyc(0, 0, 3'd0, 1, 0, "rst_hold_0");
    cyc(0, 0, 3'd0, 1, 0, "rst_hold_1");
    cyc(1, 1, 3'd0, 0, 0, "rst_release");
    // Count up from reset, through terminal count and wrap
    cyc(1, 1, 3'd1, 0, 0, "up_1");
    cyc(1, 1, 3'd2, 0, 0, "up_2");
    cyc(1, 1, 3'd3, 0, 0, "up_3");
    cyc(1, 1, 3'd4, 0, 0, "up_4");
    cyc(1, 1, 3'd5, 0, 0, "up_5");
    cyc(1, 1, 3'd6, 0, 0, "up_6");
    cyc(1, 1, 3'd7, 1, 0, "up_7_tc");
    cyc(1, 1, 3'd0, 0, 1, "up_wrap");
    // Down through zero: tc at 0, wrap pulse on arrival at 7
    cyc(1, 0, 3'd1, 0, 0, "up_1_wrap_clear");
    cyc(1, 0, 3'd0, 1, 0, "dn_0_tc");
    cyc(1, 0, 3'd7, 0, 1, "dn_wrap");
    cyc(1, 0, 3'd6, 0, 0, "dn_6");
    cyc(1, 0, 3'd5, 0, 0, "dn_5");
    // Direction change at 4: down to 3, then up to 4
    cyc(1, 0, 3'd4, 0, 0, "dn_4");
    cyc(1, 1, 3'd3, 0, 0, "dir_dn_3");
    cyc(1, 1, 3'd4, 0, 0, "dir_up_4");
    cyc(1, 1, 3'd5, 0, 0, "up_5_pre_rst");

    // Asynchronous reset mid-cycle at count 5, checked before any edge
    @(negedge clk);
    #2;
    rst = 1'b0;
    #1;
    exp_q.push_back('{c: 3'd0, t: 1'b0, w: 1'b0});
    name_q.push_back("async_rst");
    probe = 1'b1;
    #1;
    probe = 1'b0;

    cyc(0, 1, 3'd0, 0, 0, "async_rst_hold");
    cyc(1, 1, 3'd0, 0, 0, "rst_release_2");
    cyc(1, 1, 3'd1, 0, 0, "post_rst_up_1");
    cyc(1, 1, 3'd2, 0, 0, "post_rst_up_2");

    // Every queued expectation must have been consumed by the monitor
    repeat (3) @(posedge clk);
    checks = checks + 1;
    if (exp_q.size() != 0) begin
      failures = failures + 1;
      $display("FAIL scoreboard_drain: got %0d pending, expected 0", exp_q.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule : tb_three_bit_counter

`default_nettype wire
